// File: rtl/counter_alarm.sv
// Wrap-safe compare alarm behind an upstream counter, one-shot or periodic reload.
// Optional saturating missed-hit counter enabled by COUNTER_ALARM_MISS_CNT_EN.
module counter_alarm #(
  parameter logic [7:0] STATE_RESET = 8'd0,
  parameter logic [7:0] STATE_RUN   = 8'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] counter,
  input  logic [7:0]  state,
  input  logic        cmp_wen,
  input  logic [31:0] cmp_wdata,
  input  logic        period_wen,
  input  logic [31:0] period_wdata,
  input  logic        irq_ack,
`ifdef COUNTER_ALARM_MISS_CNT_EN
  output logic [7:0]  miss_cnt,
`endif
  output logic        irq,
  output logic        armed,
  output logic [31:0] cmp_cur
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FIRED
  } fsm_t;

  fsm_t        r_fsm;
  logic        r_irq;
  logic [31:0] r_cmp;
  logic [31:0] r_period;

  logic [31:0] w_diff;
  logic        w_run;
  logic        w_rst;
  logic        w_hit;
  logic        w_fire;

  // Sign of the modular difference keeps detection correct across wrap.
  assign w_diff = counter - r_cmp;
  assign w_hit  = $signed(w_diff) >= 0;
  assign w_run  = (state == STATE_RUN);
  assign w_rst  = (state == STATE_RESET);
  assign w_fire = (r_fsm == ARMED) && w_run
                && w_hit && !cmp_wen;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fsm    <= IDLE;
      r_irq    <= 1'b0;
      r_cmp    <= 32'd0;
      r_period <= 32'd0;
    end else begin
      if (period_wen)
        r_period <= period_wdata;
      if (cmp_wen) begin
        r_cmp <= cmp_wdata;
        r_fsm <= ARMED;
        if (irq_ack || w_rst)
          r_irq <= 1'b0;
      end else if (w_rst) begin
        r_fsm <= IDLE;
        r_irq <= 1'b0;
      end else if (w_fire) begin
        r_irq <= 1'b1;
        if (r_period == 32'd0)
          r_fsm <= FIRED;
        else
          r_cmp <= r_cmp + r_period;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
        if (r_fsm == FIRED)
          r_fsm <= IDLE;
      end
    end
  end

`ifdef COUNTER_ALARM_MISS_CNT_EN
  logic [7:0] r_miss;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_miss <= 8'd0;
    else if (irq_ack || w_rst)
      r_miss <= 8'd0;
    else if (w_fire && r_irq && r_miss != 8'hFF)
      r_miss <= r_miss + 8'd1;
  end

  assign miss_cnt = r_miss;
`endif

  assign irq     = r_irq;
  assign armed   = (r_fsm == ARMED);
  assign cmp_cur = r_cmp;

endmodule

// File: doc/counter_alarm.md
COUNTER_ALARM -- requirements
Module: counter_alarm

Interface
REQ-001 The block SHALL have parameter STATE_RESET, default 8'd0, meaning the state code that disarms the alarm.
REQ-002 The block SHALL have parameter STATE_RUN, default 8'd1, meaning the state code that enables hit detection.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port counter  input  32  count value from the upstream counter stage.
REQ-006 The block SHALL have port state  input  8  upstream counter state code (0 RESET, 1 RUN, 2 HALT, other values treated as HALT).
REQ-007 The block SHALL have port cmp_wen  input  1  compare-register write strobe, one cycle per write.
REQ-008 The block SHALL have port cmp_wdata  input  32  compare value written on cmp_wen.
REQ-009 The block SHALL have port period_wen  input  1  period-register write strobe.
REQ-010 The block SHALL have port period_wdata  input  32  reload period; 0 selects one-shot mode.
REQ-011 The block SHALL have port irq_ack  input  1  interrupt acknowledge, one-cycle pulse.
REQ-012 The block SHALL have port irq  output  1  level interrupt, held until acknowledged.
REQ-013 The block SHALL have port armed  output  1  high while the FSM is in ARMED.
REQ-014 The block SHALL have port cmp_cur  output  32  current compare register.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED and FIRED, and SHALL enter IDLE on reset.
REQ-016 A hit SHALL be defined as bit 31 of (counter - cmp_reg) mod 2^32 equal to 0, so detection is wrap-safe across 32'hFFFFFFFF->0.
REQ-017 At any edge where cmp_wen=1, cmp_reg SHALL load cmp_wdata and the FSM SHALL go to ARMED, regardless of its current state.
REQ-018 At an edge in ARMED with state==STATE_RUN and a hit, irq SHALL be 1 after that edge (one-cycle latency).
REQ-019 On a hit in one-shot mode (period_reg==0), the FSM SHALL go ARMED->FIRED.
REQ-020 On a hit in periodic mode, cmp_reg SHALL become cmp_reg+period_reg mod 2^32 and the FSM SHALL stay ARMED.
REQ-021 When state is HALT or unknown, detection SHALL be frozen and all registers SHALL hold.
REQ-022 When state==STATE_RESET, the FSM SHALL go to IDLE and irq SHALL clear on the next edge; cmp_reg and period_reg SHALL hold.
REQ-023 irq_ack SHALL clear irq on the next edge, and FIRED SHALL go to IDLE on irq_ack.
REQ-024 When a hit and irq_ack occur on the same edge, the hit SHALL win and irq SHALL remain 1.
REQ-025 When cmp_wen and a hit occur on the same edge, the write SHALL win and no irq SHALL be raised.
REQ-026 A period_wen write SHALL take effect for the next reload only and SHALL NOT change the FSM state.
REQ-027 The outputs armed and cmp_cur SHALL be registered, with no combinational path from inputs.

Reset
REQ-028 While resetn=0, the block SHALL force irq=0, armed=0, cmp_reg=0, period_reg=0, FSM=IDLE and miss_cnt=0 asynchronously.
REQ-029 Assertion of resetn mid-FIRED or mid-ARMED SHALL discard the pending irq.
REQ-030 The first active edge SHALL be the first clk rising edge after resetn deasserts.

Configuration
REQ-031 With macro COUNTER_ALARM_MISS_CNT_EN defined, the block SHALL add output miss_cnt [7:0], incrementing (saturating at 255) on each hit that occurs while irq=1 and irq_ack=0.
REQ-032 With COUNTER_ALARM_MISS_CNT_EN defined, miss_cnt SHALL clear on irq_ack or state==STATE_RESET.
REQ-033 Without COUNTER_ALARM_MISS_CNT_EN, the miss_cnt port and its logic SHALL be absent, with identical behaviour otherwise.

Verification
REQ-034 The bench SHALL check: cmp=100, period=0, RUN, counter ramps 0..120 -> irq rises the edge after counter=100, FSM FIRED, armed=0.
REQ-035 The bench SHALL check: cmp=32'hFFFFFFF0, period=32, counter wraps -> hit at FFFFFFF0, cmp_cur=32'h00000010, second irq after counter reaches 0x10.
REQ-036 The bench SHALL check: HALT while counter passes cmp=50 then RUN -> no irq during HALT, irq one edge after RUN resumes.
REQ-037 The bench SHALL check: irq_ack coincident with a periodic hit -> irq stays 1; a later lone ack -> irq=0.
REQ-038 The bench SHALL check: state=RESET while irq=1 -> irq=0 and armed=0 next edge, cmp_cur unchanged.
REQ-039 The bench SHALL check, with the macro defined and period=1, irq left unacknowledged for 300 hits -> miss_cnt=255, cleared by irq_ack.
